fft_frame_streamer: RTL and testbench

Collects 8-bit signed audio samples arriving at the decimated microphone rate (~12 kHz single-cycle strobes) into ping-pong frame buffers. Each completed frame is sent as an AXI4-Stream master burst with tlast into the slave data port of the FFT core. The block sits between the PDM decimator and the FFT. It is the transmitting end of the FFT's s_axis_data interface and guarantees frame-aligned, gap-tolerant delivery regardless of FFT back-pressure.

---
 rtl/fft_frame_streamer.sv | 143 ++++++++++++++
 tb/tb_fft_frame_streamer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_streamer.sv
// Ping-pong frame buffer between the audio decimator and the FFT input.
// It fills one bank while it streams the other out as an AXI4-Stream burst with tlast.
module fft_frame_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAME_LEN  = 512
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  audio_valid_in,
   input  logic [DATA_WIDTH-1:0] audio_in,
   output logic [31:0]           m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  frame_drop_out,
   output logic                  busy_out
);

   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_STREAM} state_t;

   state_t                  state_reg;
   logic [IDX_W-1:0]        fill_idx_reg;
   logic [IDX_W-1:0]        rd_idx_reg;
   logic                    fill_bank_reg;
   logic                    stream_bank_reg;
   logic                    tvalid_reg;
   logic                    tlast_reg;
   logic                    drop_reg;
   logic                    busy_reg;

   logic                    handshake;
   logic                    last_beat;
   logic                    frame_done;
   logic                    stream_free;
   logic                    rd_en;
   logic [IDX_W-1:0]        rd_addr;
   logic [DATA_WIDTH-1:0]   sample_q;
   logic [DATA_WIDTH+15:0]  sample_wide;
   logic [15:0]             real_part;

   assign handshake   = tvalid_reg & m_axis_tready;
   assign last_beat   = handshake & (rd_idx_reg == LAST_IDX);
   assign frame_done  = audio_valid_in & (fill_idx_reg == LAST_IDX);
   // A frame finishing on the very last handshake still finds the stream side free.
   assign stream_free = (state_reg == S_IDLE) | last_beat;

   // The read address looks one word ahead so the next beat is ready right after each handshake.
   assign rd_en   = (state_reg == S_PREFETCH) | handshake;
   assign rd_addr = (state_reg == S_PREFETCH) ? '0 : rd_idx_reg + 1'b1;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         logic [DATA_WIDTH-1:0] mem [FRAME_LEN];
         logic [DATA_WIDTH-1:0] q;

         always_ff @(posedge clk_in) begin
            if (audio_valid_in && (fill_bank_reg == 1'(gi)))
               mem[fill_idx_reg] <= audio_in;
            if (rd_en && (stream_bank_reg == 1'(gi)))
               q <= mem[rd_addr];
         end
      end
   endgenerate

   assign sample_q    = stream_bank_reg ? g_bank[1].q : g_bank[0].q;
   assign sample_wide = {sample_q, 16'h0000};
   assign real_part   = sample_wide[DATA_WIDTH+15 -: 16];

   // The bank read register has no reset, so the data is gated by tvalid to read zero when idle.
   assign m_axis_tdata   = tvalid_reg ? {16'h0000, real_part} : 32'h0;
   assign m_axis_tvalid  = tvalid_reg;
   assign m_axis_tlast   = tlast_reg;
   assign frame_drop_out = drop_reg;
   assign busy_out       = busy_reg;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg       <= S_IDLE;
         fill_idx_reg    <= '0;
         rd_idx_reg      <= '0;
         fill_bank_reg   <= 1'b0;
         stream_bank_reg <= 1'b0;
         tvalid_reg      <= 1'b0;
         tlast_reg       <= 1'b0;
         drop_reg        <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         drop_reg <= 1'b0;

         if (audio_valid_in)
            fill_idx_reg <= fill_idx_reg + 1'b1;

         if (frame_done) begin
            if (stream_free) begin
               stream_bank_reg <= fill_bank_reg;
               fill_bank_reg   <= ~fill_bank_reg;
            end else begin
               drop_reg <= 1'b1;
            end
         end

         case (state_reg)
            S_IDLE: begin
               if (frame_done) begin
                  state_reg <= S_PREFETCH;
                  busy_reg  <= 1'b1;
               end
            end
            S_PREFETCH: begin
               state_reg  <= S_STREAM;
               tvalid_reg <= 1'b1;
               tlast_reg  <= 1'b0;
               rd_idx_reg <= '0;
            end
            S_STREAM: begin
               if (handshake) begin
                  rd_idx_reg <= rd_idx_reg + 1'b1;
                  tlast_reg  <= (rd_addr == LAST_IDX);
                  if (rd_idx_reg == LAST_IDX) begin
                     tvalid_reg <= 1'b0;
                     tlast_reg  <= 1'b0;
                     if (frame_done) begin
                        state_reg <= S_PREFETCH;
                        busy_reg  <= 1'b1;
                     end else begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed bench for fft_frame_streamer with an 8-sample frame.
// It covers streaming, sign handling, back-pressure, frame drop, the aligned last beat and mid-stream reset.
module tb_fft_frame_streamer;

   localparam int FL = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        audio_valid = 1'b0;
   logic [7:0]  audio = 8'h00;
   logic        tready = 1'b0;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tlast;
   logic        drop;
   logic        busy;

   int total = 0;
   int bad = 0;
   int drop_cnt = 0;

   fft_frame_streamer #(.DATA_WIDTH(8), .FRAME_LEN(FL)) dut (
      .clk_in        (clk),
      .rst_in        (rst_n),
      .audio_valid_in(audio_valid),
      .audio_in      (audio),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tlast  (tlast),
      .m_axis_tready (tready),
      .frame_drop_out(drop),
      .busy_out      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (drop) drop_cnt <= drop_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_frame(input logic [7:0] s [FL]);
      for (int k = 0; k < FL; k++) begin
         audio_valid = 1'b1;
         audio = s[k];
         tick();
      end
      audio_valid = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " tvalid"}, 32'(tvalid), 32'd0);
      check({tag, " tlast"}, 32'(tlast), 32'd0);
      check({tag, " tdata"}, tdata, 32'h0);
      check({tag, " drop"}, 32'(drop), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   task automatic stream_frame(input string tag, input logic [7:0] s [FL], input bit rnd,
                               output int first_cyc);
      int k = 0;
      int cyc = 0;
      bit started = 1'b0;
      bit stall;
      logic [31:0] hd;
      logic hl;
      first_cyc = -1;
      while (k < FL && cyc < 300) begin
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stall = 1'b0;
         if (tvalid) begin
            if (!started) begin
               started = 1'b1;
               first_cyc = cyc;
            end
            if (tready) begin
               check({tag, " data"}, tdata, {16'h0000, s[k], 8'h00});
               check({tag, " last"}, 32'(tlast), 32'(k == FL - 1));
               $display("%s beat %0d tdata=%h tlast=%0d", tag, k, tdata, tlast);
               k++;
            end else begin
               stall = 1'b1;
               hd = tdata;
               hl = tlast;
            end
         end else if (started) begin
            check({tag, " gap"}, 32'(tvalid), 32'd1);
         end
         tick();
         cyc++;
         if (stall) begin
            check({tag, " hold valid"}, 32'(tvalid), 32'd1);
            check({tag, " hold data"}, tdata, hd);
            check({tag, " hold last"}, 32'(tlast), 32'(hl));
         end
      end
      if (k < FL) check({tag, " timeout"}, 32'(k), 32'(FL));
      tready = 1'b1;
   endtask

   logic [7:0] f_inc  [FL];
   logic [7:0] f_neg  [FL];
   logic [7:0] f_b    [FL];
   logic [7:0] f_c    [FL];
   logic [7:0] f_p    [FL];
   logic [7:0] f_q    [FL];
   logic [7:0] f_r    [FL];
   logic [7:0] f_s    [FL];
   int fc;
   int d0;

   initial begin
      for (int k = 0; k < FL; k++) begin
         f_inc[k] = 8'(k + 1);
         f_b[k]   = 8'(k + 9);
         f_c[k]   = 8'(k + 17);
         f_p[k]   = 8'(k + 31);
         f_q[k]   = 8'(k + 71);
         f_r[k]   = 8'(k + 41);
         f_s[k]   = 8'(k + 51);
      end
      f_neg = '{8'hFF, 8'h80, 8'h00, 8'h01, 8'h7F, 8'hFE, 8'h40, 8'hC0};

      // reset state
      tready = 1'b1;
      tick(); tick(); tick();
      check_idle_outputs("reset");
      rst_n = 1'b1;
      tick();
      check_idle_outputs("post reset");

      // basic frame with latency
      fill_frame(f_inc);
      check("t1 busy at T+1", 32'(busy), 32'd1);
      check("t1 tvalid at T+1", 32'(tvalid), 32'd0);
      stream_frame("t1", f_inc, 1'b0, fc);
      check("t1 first beat at T+2", 32'(fc), 32'd1);
      check("t1 idle after", 32'(tvalid), 32'd0);
      check("t1 busy after", 32'(busy), 32'd0);

      // negative samples
      fill_frame(f_neg);
      tick();
      check("t2 beat0 minus1", tdata, 32'h0000FF00);
      stream_frame("t2", f_neg, 1'b0, fc);

      // random back-pressure
      fill_frame(f_inc);
      stream_frame("t3", f_inc, 1'b1, fc);
      check("t3 idle after", 32'(tvalid), 32'd0);

      // stalled stream, second frame dropped, third frame intact
      tready = 1'b0;
      d0 = drop_cnt;
      fill_frame(f_inc);
      tick(); tick();
      fill_frame(f_b);
      check("t4 drop pulse", 32'(drop), 32'd1);
      tick();
      check("t4 drop single", 32'(drop), 32'd0);
      check("t4 drop count", 32'(drop_cnt - d0), 32'd1);
      check("t4 held valid", 32'(tvalid), 32'd1);
      check("t4 held data", tdata, 32'h00000100);
      stream_frame("t4a", f_inc, 1'b0, fc);
      tick();
      fill_frame(f_c);
      stream_frame("t4c", f_c, 1'b0, fc);
      tick();
      check("t4 no extra drop", 32'(drop_cnt - d0), 32'd1);

      // frame completion aligned with the last-beat handshake
      tready = 1'b1;
      d0 = drop_cnt;
      fill_frame(f_p);
      tick();
      for (int k = 0; k < FL; k++) begin
         audio_valid = 1'b1;
         audio = f_q[k];
         check("t5 valid", 32'(tvalid), 32'd1);
         check("t5 data", tdata, {16'h0000, f_p[k], 8'h00});
         check("t5 last", 32'(tlast), 32'(k == FL - 1));
         $display("t5 beat %0d tdata=%h tlast=%0d", k, tdata, tlast);
         tick();
      end
      audio_valid = 1'b0;
      check("t5 no drop", 32'(drop), 32'd0);
      check("t5 busy prefetch", 32'(busy), 32'd1);
      check("t5 idle gap", 32'(tvalid), 32'd0);
      stream_frame("t5q", f_q, 1'b0, fc);
      check("t5 next after one gap", 32'(fc), 32'd1);
      check("t5 drop count", 32'(drop_cnt - d0), 32'd0);

      // reset during beat 4
      fill_frame(f_r);
      tick(); tick(); tick(); tick();
      check("t6 beat4 data", tdata, {16'h0000, f_r[3], 8'h00});
      rst_n = 1'b0;
      #1;
      check_idle_outputs("t6 in reset");
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check_idle_outputs("t6 released");
      fill_frame(f_s);
      check("t6 busy", 32'(busy), 32'd1);
      stream_frame("t6", f_s, 1'b0, fc);
      check("t6 first beat at T+2", 32'(fc), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
